// File: rtl/raster_irq_pkg.sv
// Shared definitions for the raster interrupt block: status bit positions
// and the per-bit status update rule.
package raster_irq_pkg;

    localparam int IRQ_W   = 4;
    localparam int IRQ_RST = 0;
    localparam int IRQ_MBC = 1;
    localparam int IRQ_MMC = 2;
    localparam int IRQ_LP  = 3;

    // When a source fires in the same clock as its clear strobe, the set wins
    // so that the event is not lost.
    function automatic logic [IRQ_W-1:0] status_next(
        input logic [IRQ_W-1:0] status,
        input logic [IRQ_W-1:0] clr,
        input logic [IRQ_W-1:0] set
    );
        return (status & ~clr) | set;
    endfunction

endpackage

// File: rtl/raster_irq_lightpen_latch.sv
// Light-pen capture: synchronises lp_n, detects its falling edge and latches
// X/Y once per frame until re-armed.
module lightpen_latch #(
    parameter int LP_SYNC_STAGES = 2
) (
    input  logic       clk_dot4x,
    input  logic       rst,
    input  logic       clk_phi,
    input  logic       lp_n,
    input  logic       rearm,
    input  logic [7:0] lp_x,
    input  logic [7:0] lp_y,
    output logic [7:0] lpx,
    output logic [7:0] lpy,
    output logic       ilp_set
);

    logic [LP_SYNC_STAGES-1:0] r_sync;
    logic                      r_prev;
    logic                      r_locked;
    logic                      w_fall;

    assign w_fall  = r_prev & ~r_sync[LP_SYNC_STAGES-1];
    assign ilp_set = w_fall & ~r_locked & ~clk_phi;

    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            r_sync   <= '1;
            r_prev   <= 1'b1;
            r_locked <= 1'b0;
            lpx      <= 8'h00;
            lpy      <= 8'h00;
        end else begin
            r_sync <= {r_sync[LP_SYNC_STAGES-2:0], lp_n};
            r_prev <= r_sync[LP_SYNC_STAGES-1];
            // A pen held low across re-arm produces no new edge, so no new latch.
            if (ilp_set) begin
                lpx      <= lp_x;
                lpy      <= lp_y;
                r_locked <= 1'b1;
            end else if (rearm) begin
                r_locked <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/raster_irq.sv
// Raster interrupt source/status stage: raster compare edge detect, light pen,
// collision merge, status register with enable mask and registered irq_n.
module raster_irq
    import raster_irq_pkg::*;
#(
    parameter int LP_SYNC_STAGES = 2
) (
    input  logic        clk_dot4x,
    input  logic        rst,
    input  logic        clk_phi,
    input  logic        dot_rising_0,
    input  logic [6:0]  cycle_num,
    input  logic [8:0]  raster_line,
    input  logic [8:0]  raster_y_max,
    input  logic [9:0]  xpos,
    input  logic [8:0]  raster_cmp,
    input  logic [3:0]  irq_en,
    input  logic [3:0]  irq_clr,
    input  logic        mmc_evt,
    input  logic        mbc_evt,
    input  logic        lp_n,
    output logic [3:0]  irq_status,
    output logic        irq_any,
    output logic        irq_n,
    output logic [7:0]  lpx,
    output logic [7:0]  lpy
);

    logic              w_line0;
    logic              w_match;
    logic              w_rearm;
    logic              w_ilp_set;
    logic [IRQ_W-1:0]  w_set;
    logic              r_match_q;
    logic              w_unused;

    // A compare value beyond the last line simply never matches.
    assign w_unused = &{1'b0, raster_y_max, xpos[9], xpos[0]};

    assign w_line0 = (raster_line == 9'd0);
    // Line 0 compare is held off until cycle 1 so the wrap is seen in a stable cycle.
    assign w_match = (raster_line == raster_cmp) && !(w_line0 && cycle_num == 7'd0);
    assign w_rearm = w_line0 && (cycle_num == 7'd1) && dot_rising_0;

    lightpen_latch #(
        .LP_SYNC_STAGES(LP_SYNC_STAGES)
    ) u_lp (
        .clk_dot4x (clk_dot4x),
        .rst       (rst),
        .clk_phi   (clk_phi),
        .lp_n      (lp_n),
        .rearm     (w_rearm),
        .lp_x      (xpos[8:1]),
        .lp_y      (raster_line[7:0]),
        .lpx       (lpx),
        .lpy       (lpy),
        .ilp_set   (w_ilp_set)
    );

    always_comb begin
        w_set          = '0;
        w_set[IRQ_RST] = w_match & ~r_match_q;
        w_set[IRQ_MBC] = mbc_evt;
        w_set[IRQ_MMC] = mmc_evt;
        w_set[IRQ_LP]  = w_ilp_set;
    end

    assign irq_any = |(irq_status & irq_en);

    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            r_match_q  <= 1'b0;
            irq_status <= '0;
            irq_n      <= 1'b1;
        end else begin
            r_match_q  <= w_match;
            irq_status <= status_next(irq_status, irq_clr, w_set);
            irq_n      <= ~irq_any;
        end
    end

endmodule

// File: tb/tb_raster_irq.sv
// Directed bench for raster_irq: raster compare, frame wrap, light pen,
// collision set/clear priority and mid-frame reset.
module tb_raster_irq;

    logic       clk_dot4x = 1'b0;
    logic       rst, clk_phi, dot_rising_0, mmc_evt, mbc_evt, lp_n;
    logic [6:0] cycle_num;
    logic [8:0] raster_line, raster_y_max, raster_cmp;
    logic [9:0] xpos;
    logic [3:0] irq_en, irq_clr, irq_status;
    logic       irq_any, irq_n;
    logic [7:0] lpx, lpy;

    int n_pass = 0;
    int n_total = 0;

    raster_irq #(.LP_SYNC_STAGES(2)) dut (
        .clk_dot4x    (clk_dot4x),
        .rst          (rst),
        .clk_phi      (clk_phi),
        .dot_rising_0 (dot_rising_0),
        .cycle_num    (cycle_num),
        .raster_line  (raster_line),
        .raster_y_max (raster_y_max),
        .xpos         (xpos),
        .raster_cmp   (raster_cmp),
        .irq_en       (irq_en),
        .irq_clr      (irq_clr),
        .mmc_evt      (mmc_evt),
        .mbc_evt      (mbc_evt),
        .lp_n         (lp_n),
        .irq_status   (irq_status),
        .irq_any      (irq_any),
        .irq_n        (irq_n),
        .lpx          (lpx),
        .lpy          (lpy)
    );

    always #5 clk_dot4x = ~clk_dot4x;

    task automatic tick(input int n);
        repeat (n) @(posedge clk_dot4x);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; clk_phi = 1'b0; dot_rising_0 = 1'b0; mmc_evt = 1'b0; mbc_evt = 1'b0;
        lp_n = 1'b1; cycle_num = 7'd0; raster_line = 9'd0; raster_y_max = 9'h137;
        raster_cmp = 9'h1FF; xpos = 10'd0; irq_en = 4'h0; irq_clr = 4'h0;
        tick(2);
        chk("rst_status", 16'(irq_status), 16'h0);
        chk("rst_irq_n",  16'(irq_n), 16'h1);
        chk("rst_any",    16'(irq_any), 16'h0);
        chk("rst_lpx",    16'(lpx), 16'h0);
        chk("rst_lpy",    16'(lpy), 16'h0);
        rst = 1'b0;

        // 1: compare at line 0x030 with ERST enabled
        raster_cmp = 9'h030; irq_en = 4'b0001; cycle_num = 7'd5; raster_line = 9'h02F;
        tick(1);
        chk("t1_before", 16'(irq_status), 16'h0);
        raster_line = 9'h030;
        tick(1);
        chk("t1_set",     16'(irq_status), 16'h1);
        chk("t1_irqn_lag", 16'(irq_n), 16'h1);
        tick(1);
        chk("t1_irqn_low", 16'(irq_n), 16'h0);
        irq_clr = 4'b0001;
        tick(1);
        irq_clr = 4'b0000;
        chk("t1_clr", 16'(irq_status), 16'h0);
        tick(2);
        chk("t1_once", 16'(irq_status), 16'h0);
        chk("t1_irqn_rel", 16'(irq_n), 16'h1);
        raster_line = 9'h031;
        tick(1);
        chk("t1_next_line", 16'(irq_status), 16'h0);

        // 2: compare 0 across frame wrap
        raster_cmp = 9'h000; raster_line = 9'h137; cycle_num = 7'd62;
        tick(1);
        raster_line = 9'h000; cycle_num = 7'd0;
        tick(1);
        chk("t2_cyc0", 16'(irq_status), 16'h0);
        cycle_num = 7'd1;
        tick(1);
        chk("t2_cyc1", 16'(irq_status), 16'h1);
        irq_clr = 4'b0001;
        tick(1);
        irq_clr = 4'b0000;

        // 3: compare written to current line mid-line
        raster_line = 9'h050; cycle_num = 7'd20; raster_cmp = 9'h000;
        tick(1);
        chk("t3_nomatch", 16'(irq_status), 16'h0);
        raster_cmp = 9'h050;
        tick(1);
        chk("t3_write_set", 16'(irq_status), 16'h1);
        irq_clr = 4'b0001;
        tick(1);
        irq_clr = 4'b0000;
        tick(2);
        chk("t3_no_reset", 16'(irq_status), 16'h0);

        // 4: light pen latch, lock, re-arm
        irq_en = 4'h0; raster_line = 9'h07F; xpos = 10'h0A4; lp_n = 1'b0;
        tick(2);
        chk("t4_sync_lat", 16'(lpx), 16'h00);
        tick(1);
        chk("t4_lpx", 16'(lpx), 16'h52);
        chk("t4_lpy", 16'(lpy), 16'h7F);
        chk("t4_ilp", 16'(irq_status), 16'h8);
        lp_n = 1'b1;
        tick(3);
        raster_line = 9'h090; xpos = 10'h100; lp_n = 1'b0;
        tick(3);
        chk("t4_locked_x", 16'(lpx), 16'h52);
        chk("t4_locked_y", 16'(lpy), 16'h7F);
        lp_n = 1'b1;
        tick(3);
        raster_line = 9'h000; cycle_num = 7'd1; dot_rising_0 = 1'b1;
        tick(1);
        dot_rising_0 = 1'b0;
        raster_line = 9'h0A0; cycle_num = 7'd30; xpos = 10'h0C8; lp_n = 1'b0;
        tick(3);
        chk("t4_rearm_x", 16'(lpx), 16'h64);
        chk("t4_rearm_y", 16'(lpy), 16'hA0);
        lp_n = 1'b1;

        // 5: set wins over clear, disabled source keeps irq_n high
        irq_clr = 4'hF;
        tick(1);
        irq_clr = 4'h0;
        chk("t5_cleared", 16'(irq_status), 16'h0);
        mbc_evt = 1'b1;
        tick(1);
        chk("t5_mbc", 16'(irq_status), 16'h2);
        irq_clr = 4'b0010;
        tick(1);
        mbc_evt = 1'b0; irq_clr = 4'h0;
        chk("t5_set_wins", 16'(irq_status), 16'h2);
        mmc_evt = 1'b1;
        tick(1);
        mmc_evt = 1'b0;
        chk("t5_mmc", 16'(irq_status), 16'h6);
        tick(1);
        chk("t5_disabled_irqn", 16'(irq_n), 16'h1);
        irq_en = 4'b0100;
        #1;
        chk("t5_any", 16'(irq_any), 16'h1);
        chk("t5_irqn_lag", 16'(irq_n), 16'h1);
        tick(1);
        chk("t5_irqn_low", 16'(irq_n), 16'h0);

        // 6: reset mid-line with all status set
        lp_n = 1'b0;
        raster_line = 9'h050;
        tick(1);
        chk("t6_rst_set", 16'(irq_status), 16'h7);
        irq_clr = 4'h0;
        lp_n = 1'b1;
        raster_cmp = 9'h1FF; irq_en = 4'hF;
        tick(1);
        rst = 1'b1;
        tick(1);
        chk("t6_status", 16'(irq_status), 16'h0);
        chk("t6_irq_n",  16'(irq_n), 16'h1);
        chk("t6_lpx",    16'(lpx), 16'h00);
        chk("t6_lpy",    16'(lpy), 16'h00);
        rst = 1'b0;
        raster_line = 9'h033; xpos = 10'h022; lp_n = 1'b0;
        tick(3);
        chk("t6_rearm_x", 16'(lpx), 16'h11);
        chk("t6_rearm_y", 16'(lpy), 16'h33);
        chk("t6_ilp",     16'(irq_status), 16'h8);
        lp_n = 1'b1;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
